// File: rtl/ad_pkg.sv
// Shared definitions for the AD sample chain: sample width, filter state encoding
// and the running-sum width helper.
package ad_pkg;

  localparam int unsigned AD_W = 8;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } ad_state_e;

  function automatic int unsigned sum_width(input int unsigned sample_w,
                                            input int unsigned log2_depth);
    return sample_w + log2_depth;
  endfunction

endpackage

// File: rtl/ad_sample_ring.sv
// Circular sample buffer for the moving-average filter: exposes the entry about to be
// overwritten, writes on accept, and clears synchronously on reset or flush.
module ad_sample_ring
  import ad_pkg::*;
#(
  parameter int unsigned AD_W       = ad_pkg::AD_W,
  parameter int unsigned LOG2_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            wr_en,
  input  logic [AD_W-1:0] din,
  output logic [AD_W-1:0] old_val
);

  localparam int unsigned DEPTH = 1 << LOG2_DEPTH;

  logic [AD_W-1:0]       mem [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= din;
      wr_ptr      <= wr_ptr + 1'b1;
    end
  end

  assign old_val = mem[wr_ptr];

endmodule

// File: rtl/ad_avg_filter.sv
// Boxcar moving average over the last 2^LOG2_DEPTH accepted AD samples.
// Optional peak-hold output enabled by defining AD_PEAK_HOLD_EN.
module ad_avg_filter
  import ad_pkg::*;
#(
  parameter int unsigned AD_W       = ad_pkg::AD_W,
  parameter int unsigned LOG2_DEPTH = 2
) (
  input  logic            adck,
  input  logic            reset,
  input  logic [AD_W-1:0] ad_in,
  input  logic            sample_en,
  input  logic            clr,
  output logic [AD_W-1:0] avg_out,
  output logic            avg_valid,
  output logic            filled
`ifdef AD_PEAK_HOLD_EN
  ,
  output logic [AD_W-1:0] peak_out
`endif
);

  localparam int unsigned SW = sum_width(AD_W, LOG2_DEPTH);
  localparam logic [LOG2_DEPTH:0] FULL = {1'b1, {LOG2_DEPTH{1'b0}}};

  ad_state_e             state;
  logic [SW-1:0]         sum;
  logic [SW-1:0]         sum_next;
  logic [LOG2_DEPTH:0]   fill_cnt;
  logic [LOG2_DEPTH:0]   fill_next;
  logic                  full_next;
  logic [AD_W-1:0]       old_val;
  logic [AD_W-1:0]       avg_next;

  // clr drops a coincident sample, so the ring must not see it as a write
  ad_sample_ring #(
    .AD_W       (AD_W),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_ring (
    .clk     (adck),
    .reset   (reset),
    .clr     (clr),
    .wr_en   (sample_en && !clr),
    .din     (ad_in),
    .old_val (old_val)
  );

  always_comb begin
    sum_next  = sum + SW'(ad_in) - SW'(old_val);
    fill_next = (fill_cnt == FULL) ? fill_cnt : fill_cnt + 1'b1;
    full_next = (fill_next == FULL);
    avg_next  = sum_next[SW-1:LOG2_DEPTH];
  end

  always_ff @(posedge adck) begin
    if (reset) begin
      state     <= FILL;
      sum       <= '0;
      fill_cnt  <= '0;
      avg_out   <= '0;
      avg_valid <= 1'b0;
      filled    <= 1'b0;
`ifdef AD_PEAK_HOLD_EN
      peak_out  <= '0;
`endif
    end else if (clr) begin
      state     <= FILL;
      sum       <= '0;
      fill_cnt  <= '0;
      avg_valid <= 1'b0;
      filled    <= 1'b0;
    end else if (sample_en) begin
      sum       <= sum_next;
      fill_cnt  <= fill_next;
      avg_out   <= avg_next;
      avg_valid <= full_next;
      if (full_next) begin
        state  <= RUN;
        filled <= 1'b1;
      end
`ifdef AD_PEAK_HOLD_EN
      if (full_next && (avg_next > peak_out)) peak_out <= avg_next;
`endif
    end else begin
      avg_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ad_avg_filter.sv
// Directed bench for ad_avg_filter with LOG2_DEPTH=2; peak-hold checks run when
// AD_PEAK_HOLD_EN is defined.
module tb_ad_avg_filter;

  logic       adck = 1'b0;
  logic       reset;
  logic [7:0] ad_in;
  logic       sample_en;
  logic       clr;
  logic [7:0] avg_out;
  logic       avg_valid;
  logic       filled;
`ifdef AD_PEAK_HOLD_EN
  logic [7:0] peak_out;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  ad_avg_filter #(
    .AD_W       (8),
    .LOG2_DEPTH (2)
  ) dut (
    .adck      (adck),
    .reset     (reset),
    .ad_in     (ad_in),
    .sample_en (sample_en),
    .clr       (clr),
    .avg_out   (avg_out),
    .avg_valid (avg_valid),
    .filled    (filled)
`ifdef AD_PEAK_HOLD_EN
    ,
    .peak_out  (peak_out)
`endif
  );

  always #5 adck = ~adck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge adck);
    #1;
  endtask

  task automatic smp(input logic [7:0] d);
    ad_in     = d;
    sample_en = 1'b1;
    step();
  endtask

  task automatic idle();
    ad_in     = 8'hFF;
    sample_en = 1'b0;
    step();
  endtask

  task automatic chk_out(input string tag, input logic [7:0] a, input logic v, input logic f);
    chk({tag, "_avg"}, {24'd0, avg_out}, {24'd0, a});
    chk({tag, "_valid"}, {31'd0, avg_valid}, {31'd0, v});
    chk({tag, "_filled"}, {31'd0, filled}, {31'd0, f});
  endtask

  logic [7:0] ramp_exp [6];

  initial begin
    reset     = 1'b1;
    clr       = 1'b0;
    sample_en = 1'b0;
    ad_in     = 8'h00;
    step();
    chk_out("reset", 8'h00, 1'b0, 1'b0);
`ifdef AD_PEAK_HOLD_EN
    chk("reset_peak", {24'd0, peak_out}, 32'h0);
`endif
    reset = 1'b0;

    // fill with a constant 0x40
    for (int i = 0; i < 6; i++) begin
      smp(8'h40);
      chk_out($sformatf("fill%0d", i), (i < 4) ? 8'(8'h10 * (i + 1)) : 8'h40,
              (i >= 3), (i >= 3));
    end

    // ramp through a window of 40s; wr_ptr wraps during this sequence
    ramp_exp = '{8'h30, 8'h21, 8'h13, 8'h06, 8'h0A, 8'h0E};
    for (int i = 0; i < 6; i++) begin
      smp(8'(4 * i));
      chk_out($sformatf("ramp%0d", i), ramp_exp[i], 1'b1, 1'b1);
    end

    // full-scale then drain to zero
    for (int i = 0; i < 8; i++) smp(8'hFF);
    chk_out("ff", 8'hFF, 1'b1, 1'b1);
    smp(8'h00); chk_out("drain0", 8'hBF, 1'b1, 1'b1);
    smp(8'h00); chk_out("drain1", 8'h7F, 1'b1, 1'b1);
    smp(8'h00); chk_out("drain2", 8'h3F, 1'b1, 1'b1);
    smp(8'h00); chk_out("drain3", 8'h00, 1'b1, 1'b1);

    // sample_en gaps in RUN
    smp(8'h20); chk_out("gap_s0", 8'h08, 1'b1, 1'b1);
    idle();     chk_out("gap_i0", 8'h08, 1'b0, 1'b1);
    idle();     chk_out("gap_i1", 8'h08, 1'b0, 1'b1);
    smp(8'h20); chk_out("gap_s1", 8'h10, 1'b1, 1'b1);

    // clr in RUN with a coincident sample
    clr = 1'b1; smp(8'h80); clr = 1'b0;
    chk_out("clr_run", 8'h10, 1'b0, 1'b0);
    smp(8'h80); chk_out("refill0", 8'h20, 1'b0, 1'b0);
    smp(8'h80); chk_out("refill1", 8'h40, 1'b0, 1'b0);
    // clr in FILL: the two 80s and the coincident sample must be gone
    clr = 1'b1; smp(8'hC0); clr = 1'b0;
    chk_out("clr_fill", 8'h40, 1'b0, 1'b0);
    smp(8'h08); chk_out("post0", 8'h02, 1'b0, 1'b0);
    smp(8'h08); chk_out("post1", 8'h04, 1'b0, 1'b0);
    smp(8'h08); chk_out("post2", 8'h06, 1'b0, 1'b0);
    smp(8'h08); chk_out("post3", 8'h08, 1'b1, 1'b1);

    // reset mid-RUN with a sample offered
    reset = 1'b1; smp(8'hFF); reset = 1'b0;
    chk_out("reset_run", 8'h00, 1'b0, 1'b0);
    sample_en = 1'b0;

`ifdef AD_PEAK_HOLD_EN
    for (int i = 0; i < 4; i++) smp(8'h20);
    chk("pk20_avg", {24'd0, avg_out}, 32'h20);
    chk("pk20", {24'd0, peak_out}, 32'h20);
    for (int i = 0; i < 4; i++) smp(8'h80);
    chk("pk80_avg", {24'd0, avg_out}, 32'h80);
    chk("pk80", {24'd0, peak_out}, 32'h80);
    for (int i = 0; i < 4; i++) smp(8'h50);
    chk("pk50_avg", {24'd0, avg_out}, 32'h50);
    chk("pk50", {24'd0, peak_out}, 32'h80);
    clr = 1'b1; idle(); clr = 1'b0;
    chk("pk_clr", {24'd0, peak_out}, 32'h80);
    reset = 1'b1; idle(); reset = 1'b0;
    chk("pk_reset", {24'd0, peak_out}, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
